// File: rtl/ad80305_pkg.sv
// Shared definitions for the AD80305 receive DC-offset correction stage.
// Holds the default sample width, saturation limits and the estimator state encoding.
package ad80305_pkg;

    localparam int DW = 12;

    // Saturation limits for a signed dw-bit sample.
    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } est_state_e;

endpackage

// File: rtl/ad80305_dc_est.sv
// Windowed-average DC estimator shared by I and Q: one FSM, one window counter,
// one accumulator per channel, and the registered estimates.
module ad80305_dc_est #(
    parameter int DW       = ad80305_pkg::DW,
    parameter int ACC_LOG2 = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 est_en,
    input  logic                 strobe,
    input  logic signed [DW-1:0] idata,
    input  logic signed [DW-1:0] qdata,
    output logic                 est_valid,
    output logic signed [DW-1:0] dc_est_i,
    output logic signed [DW-1:0] dc_est_q
);
    import ad80305_pkg::*;

    localparam int AW = DW + ACC_LOG2;
    localparam logic [ACC_LOG2-1:0] CNT_LAST = '1;

    est_state_e            state_q, state_d;
    logic [ACC_LOG2-1:0]   cnt_q, cnt_d;
    logic signed [AW-1:0]  acc_i_q, acc_i_d;
    logic signed [AW-1:0]  acc_q_q, acc_q_d;
    logic signed [DW-1:0]  est_i_q, est_i_d;
    logic signed [DW-1:0]  est_q_q, est_q_d;
    logic                  valid_q, valid_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        est_i_d = est_i_q;
        est_q_d = est_q_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                acc_i_d = '0;
                acc_q_d = '0;
                if (est_en) state_d = ACCUM;
            end
            ACCUM: begin
                if (!est_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_i_d = '0;
                    acc_q_d = '0;
                end else if (strobe) begin
                    acc_i_d = acc_i_q + AW'(idata);
                    acc_q_d = acc_q_q + AW'(qdata);
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = UPDATE;
                end
            end
            UPDATE: begin
                // Dropping the low bits of a signed sum is an arithmetic shift: floor division.
                est_i_d = acc_i_q[AW-1:ACC_LOG2];
                est_q_d = acc_q_q[AW-1:ACC_LOG2];
                valid_d = 1'b1;
                if (strobe && est_en) begin
                    acc_i_d = AW'(idata);
                    acc_q_d = AW'(qdata);
                    cnt_d   = ACC_LOG2'(1);
                end else begin
                    acc_i_d = '0;
                    acc_q_d = '0;
                    cnt_d   = '0;
                end
                state_d = est_en ? ACCUM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
            est_i_q <= '0;
            est_q_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            est_i_q <= est_i_d;
            est_q_q <= est_q_d;
            valid_q <= valid_d;
        end
    end

    assign est_valid = valid_q;
    assign dc_est_i  = est_i_q;
    assign dc_est_q  = est_q_q;

endmodule

// File: rtl/ad80305_rx_dc_corr.sv
// Receive-path DC-offset correction: subtract estimate and trim, saturate, and
// forward with a fixed 2-cycle latency; bypass keeps the same latency.
module ad80305_rx_dc_corr #(
    parameter int ACC_LOG2 = 12,
    parameter int DW       = ad80305_pkg::DW
) (
    input  logic                 i_fpga_clk_125p,
    input  logic                 i_fpga_rst_125p,
    input  logic                 i_iq_corr_bypass,
    input  logic signed [7:0]    i_dc_corr_idata,
    input  logic signed [7:0]    i_dc_corr_qdata,
    input  logic                 i_est_en,
    input  logic                 i_iqdata_fp,
    input  logic signed [DW-1:0] i_idata,
    input  logic signed [DW-1:0] i_qdata,
    output logic                 o_iqdata_fp,
    output logic signed [DW-1:0] o_idata,
    output logic signed [DW-1:0] o_qdata,
    output logic                 o_est_valid,
    output logic signed [DW-1:0] o_dc_est_i,
    output logic signed [DW-1:0] o_dc_est_q
);
    import ad80305_pkg::*;

    // Two guard bits cover sample minus estimate minus trim without wrap.
    localparam int EW = DW + 2;
    localparam logic signed [EW-1:0] SAT_HI_X = EW'(sat_max(DW));
    localparam logic signed [EW-1:0] SAT_LO_X = EW'(sat_min(DW));
    localparam logic signed [DW-1:0] SAT_HI   = DW'(sat_max(DW));
    localparam logic signed [DW-1:0] SAT_LO   = DW'(sat_min(DW));

    logic signed [DW-1:0] dc_est_i, dc_est_q;

    logic                 fp1_q, fp1_d;
    logic signed [EW-1:0] d_i_q, d_i_d;
    logic signed [EW-1:0] d_q_q, d_q_d;
    logic                 fp2_q, fp2_d;
    logic signed [DW-1:0] out_i_q, out_i_d;
    logic signed [DW-1:0] out_q_q, out_q_d;

    function automatic logic signed [DW-1:0] saturate(input logic signed [EW-1:0] v);
        if (v > SAT_HI_X)      return SAT_HI;
        else if (v < SAT_LO_X) return SAT_LO;
        else                   return v[DW-1:0];
    endfunction

    ad80305_dc_est #(
        .DW       (DW),
        .ACC_LOG2 (ACC_LOG2)
    ) u_dc_est (
        .clk       (i_fpga_clk_125p),
        .rst       (i_fpga_rst_125p),
        .est_en    (i_est_en),
        .strobe    (i_iqdata_fp),
        .idata     (i_idata),
        .qdata     (i_qdata),
        .est_valid (o_est_valid),
        .dc_est_i  (dc_est_i),
        .dc_est_q  (dc_est_q)
    );

    always_comb begin
        fp1_d   = i_iqdata_fp;
        d_i_d   = d_i_q;
        d_q_d   = d_q_q;
        fp2_d   = fp1_q;
        out_i_d = out_i_q;
        out_q_d = out_q_q;

        if (i_iqdata_fp) begin
            if (i_iq_corr_bypass) begin
                d_i_d = EW'(i_idata);
                d_q_d = EW'(i_qdata);
            end else begin
                d_i_d = EW'(i_idata) - EW'(dc_est_i) - EW'(i_dc_corr_idata);
                d_q_d = EW'(i_qdata) - EW'(dc_est_q) - EW'(i_dc_corr_qdata);
            end
        end

        if (fp1_q) begin
            out_i_d = saturate(d_i_q);
            out_q_d = saturate(d_q_q);
        end
    end

    always_ff @(posedge i_fpga_clk_125p) begin
        if (i_fpga_rst_125p) begin
            fp1_q   <= 1'b0;
            d_i_q   <= '0;
            d_q_q   <= '0;
            fp2_q   <= 1'b0;
            out_i_q <= '0;
            out_q_q <= '0;
        end else begin
            fp1_q   <= fp1_d;
            d_i_q   <= d_i_d;
            d_q_q   <= d_q_d;
            fp2_q   <= fp2_d;
            out_i_q <= out_i_d;
            out_q_q <= out_q_d;
        end
    end

    assign o_iqdata_fp = fp2_q;
    assign o_idata     = out_i_q;
    assign o_qdata     = out_q_q;
    assign o_dc_est_i  = dc_est_i;
    assign o_dc_est_q  = dc_est_q;

endmodule

// File: tb/tb_ad80305_rx_dc_corr.sv
// Self-checking bench for ad80305_rx_dc_corr: directed vector table, multi-cycle
// estimation sequences and randomized traffic against a behavioural model.
module tb_ad80305_rx_dc_corr;

    localparam int DW       = 12;
    localparam int ACC_LOG2 = 4;
    localparam int N        = 1 << ACC_LOG2;
    localparam int SMAX     = 2047;
    localparam int SMIN     = -2048;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 bypass = 1'b0;
    logic                 est_en = 1'b0;
    logic                 fp = 1'b0;
    logic signed [7:0]    trim_i = '0;
    logic signed [7:0]    trim_q = '0;
    logic signed [DW-1:0] xi = '0;
    logic signed [DW-1:0] xq = '0;

    logic                 o_fp;
    logic signed [DW-1:0] o_i, o_q;
    logic                 o_valid;
    logic signed [DW-1:0] o_est_i, o_est_q;

    ad80305_rx_dc_corr #(
        .ACC_LOG2 (ACC_LOG2),
        .DW       (DW)
    ) dut (
        .i_fpga_clk_125p  (clk),
        .i_fpga_rst_125p  (rst),
        .i_iq_corr_bypass (bypass),
        .i_dc_corr_idata  (trim_i),
        .i_dc_corr_qdata  (trim_q),
        .i_est_en         (est_en),
        .i_iqdata_fp      (fp),
        .i_idata          (xi),
        .i_qdata          (xq),
        .o_iqdata_fp      (o_fp),
        .o_idata          (o_i),
        .o_qdata          (o_q),
        .o_est_valid      (o_valid),
        .o_dc_est_i       (o_est_i),
        .o_dc_est_q       (o_est_q)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input integer act, input integer exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: the window is a queue of raw samples, the estimate is
    // the floored mean of a full window, the datapath is a two-entry delay line.
    int  m_est_i = 0, m_est_q = 0;
    int  win_i[$], win_q[$];
    bit  collecting = 0, window_full = 0;
    bit  p1_fp = 0;
    int  p1_i = 0, p1_q = 0;
    bit  e_fp = 0, e_valid = 0;
    int  e_i = 0, e_q = 0;

    function automatic int clamp(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic int floor_mean(input int s);
        int q;
        q = s / N;
        if ((s % N) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int qsum(input int q[$]);
        int s;
        s = 0;
        foreach (q[k]) s += q[k];
        return s;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_est_i = 0; m_est_q = 0;
            win_i.delete(); win_q.delete();
            collecting = 0; window_full = 0;
            p1_fp = 0; p1_i = 0; p1_q = 0;
            e_fp = 0; e_i = 0; e_q = 0; e_valid = 0;
            return;
        end
        e_fp = p1_fp;
        if (p1_fp) begin
            e_i = clamp(p1_i);
            e_q = clamp(p1_q);
        end
        p1_fp = fp;
        if (fp) begin
            p1_i = bypass ? int'(xi) : int'(xi) - m_est_i - int'(trim_i);
            p1_q = bypass ? int'(xq) : int'(xq) - m_est_q - int'(trim_q);
        end
        e_valid = 0;
        if (!collecting) begin
            win_i.delete(); win_q.delete();
            collecting = est_en;
        end else if (window_full) begin
            m_est_i = floor_mean(qsum(win_i));
            m_est_q = floor_mean(qsum(win_q));
            e_valid = 1;
            win_i.delete(); win_q.delete();
            window_full = 0;
            if (!est_en) collecting = 0;
            else if (fp) begin
                win_i.push_back(int'(xi));
                win_q.push_back(int'(xq));
            end
        end else if (!est_en) begin
            collecting = 0;
            win_i.delete(); win_q.delete();
        end else if (fp) begin
            win_i.push_back(int'(xi));
            win_q.push_back(int'(xq));
            if (win_i.size() == N) window_full = 1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("model_fp", o_fp, e_fp);
        check("model_i", $signed(o_i), e_i);
        check("model_q", $signed(o_q), e_q);
        check("model_valid", o_valid, e_valid);
        check("model_est_i", $signed(o_est_i), m_est_i);
        check("model_est_q", $signed(o_est_q), m_est_q);
    endtask

    typedef struct {
        logic byp;
        int   t_i, t_q, x_i, x_q, exp_i, exp_q;
    } vec_t;

    vec_t vecs[7];
    int   pulses;

    initial begin
        vecs[0] = '{1'b1,    5,   -3,   100,   -50,   100,   -50};
        vecs[1] = '{1'b0,    5,   -3,   100,   -50,    95,   -47};
        vecs[2] = '{1'b0,  -10,   10,  2047, -2048,  2047, -2048};
        vecs[3] = '{1'b0,   -5,    0,  2040,     0,  2045,     0};
        vecs[4] = '{1'b1, -128,  127, -2048,  2047, -2048,  2047};
        vecs[5] = '{1'b0,  127, -128, -2048,  2047, -2048,  2047};
        vecs[6] = '{1'b0, -128,  127,     0,     0,   128,  -127};

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_fp", o_fp, 0);
        check("rst_i", $signed(o_i), 0);
        check("rst_est_i", $signed(o_est_i), 0);
        check("rst_valid", o_valid, 0);
        rst = 1'b0;
        tick();

        // Directed vectors: strobe once, expect the result two cycles later, then hold
        foreach (vecs[v]) begin
            bypass = vecs[v].byp;
            trim_i = 8'(vecs[v].t_i);
            trim_q = 8'(vecs[v].t_q);
            xi = DW'(vecs[v].x_i);
            xq = DW'(vecs[v].x_q);
            fp = 1'b1;
            tick();
            fp = 1'b0;
            tick();
            check("vec_fp", o_fp, 1);
            check("vec_i", $signed(o_i), vecs[v].exp_i);
            check("vec_q", $signed(o_q), vecs[v].exp_q);
            tick();
            check("vec_fp_low", o_fp, 0);
            check("vec_hold_i", $signed(o_i), vecs[v].exp_i);
        end

        // Constant-input estimation window
        bypass = 1'b0; trim_i = '0; trim_q = '0;
        est_en = 1'b1;
        tick();
        pulses = 0;
        for (int k = 0; k < N; k++) begin
            fp = 1'b1; xi = 12'sd40; xq = -12'sd24;
            tick();
            if (o_valid) pulses++;
        end
        fp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (o_valid) pulses++;
        end
        est_en = 1'b0;
        check("est_pulses", pulses, 1);
        check("est_i_40", $signed(o_est_i), 40);
        check("est_q_m24", $signed(o_est_q), -24);
        fp = 1'b1;
        tick();
        fp = 1'b0;
        tick();
        check("corr_i_zero", $signed(o_i), 0);
        check("corr_q_zero", $signed(o_q), 0);

        // Rounding toward minus infinity
        est_en = 1'b1;
        tick();
        for (int k = 0; k < N; k++) begin
            fp = 1'b1; xi = (k % 2 == 0) ? -12'sd1 : 12'sd0; xq = '0;
            tick();
        end
        fp = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        est_en = 1'b0;
        check("round_est_i", $signed(o_est_i), -1);
        check("round_est_q", $signed(o_est_q), 0);

        // Abort after 10 strobes
        est_en = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            fp = 1'b1; xi = 12'sd500; xq = 12'sd300;
            tick();
        end
        est_en = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            fp = k[0];
            tick();
            if (o_valid) pulses++;
        end
        fp = 1'b0;
        check("abort_pulses", pulses, 0);
        check("abort_est_i", $signed(o_est_i), -1);
        check("abort_est_q", $signed(o_est_q), 0);

        // Reset mid-window, then a fresh window from zero
        est_en = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            fp = 1'b1; xi = 12'sd1000; xq = -12'sd1000;
            tick();
        end
        rst = 1'b1;
        tick();
        check("mid_rst_fp", o_fp, 0);
        check("mid_rst_i", $signed(o_i), 0);
        check("mid_rst_q", $signed(o_q), 0);
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_est_i", $signed(o_est_i), 0);
        check("mid_rst_est_q", $signed(o_est_q), 0);
        rst = 1'b0;
        fp = 1'b0;
        tick();
        for (int k = 0; k < N; k++) begin
            fp = 1'b1; xi = 12'sd100; xq = -12'sd100;
            tick();
        end
        fp = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("restart_est_i", $signed(o_est_i), 100);
        check("restart_est_q", $signed(o_est_q), -100);

        // Randomized traffic against the model
        pulses = 0;
        est_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (est_en) est_en = ($urandom_range(0, 99) != 0);
            else        est_en = ($urandom_range(0, 4) == 0);
            rst    = ($urandom_range(0, 599) == 0);
            fp     = ($urandom_range(0, 3) != 0);
            bypass = ($urandom_range(0, 7) == 0);
            trim_i = 8'($urandom);
            trim_q = 8'($urandom);
            xi     = DW'($urandom);
            xq     = DW'($urandom);
            if ($urandom_range(0, 9) == 0) xi = ($urandom_range(0, 1) != 0) ? 12'sd2047 : -12'sd2048;
            if ($urandom_range(0, 9) == 0) xq = ($urandom_range(0, 1) != 0) ? 12'sd2047 : -12'sd2048;
            tick();
            if (o_valid) pulses++;
        end
        rst = 1'b0; fp = 1'b0;
        check("rand_windows_seen", (pulses > 0) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad80305_rx_dc_corr.md
# ad80305_rx_dc_corr

Receive-path DC-offset correction stage. It sits directly downstream of the AD80305 LVCMOS DDR receive interface in the 125 MHz FPGA domain and consumes its strobed 12-bit I/Q pairs. It estimates the DC offset per channel by windowed averaging, subtracts the estimate and a static trim, saturates the result, and forwards it with a fixed latency. A bypass mode passes the data through untouched with the same latency.

## Interface
- `ACC_LOG2`, default 12: log2 of the number of strobed samples in one estimation window.
- `DW`, default 12: sample width in bits.
- `i_fpga_clk_125p`, in, 1: system clock.
- `i_fpga_rst_125p`, in, 1: reset. Synchronous and active-high.
- `i_iq_corr_bypass`, in, 1: when 1, the correction is bypassed. It is sampled with each strobe.
- `i_dc_corr_idata`, in, 8, signed: static I trim. It is subtracted after the estimate.
- `i_dc_corr_qdata`, in, 8, signed: static Q trim.
- `i_est_en`, in, 1: enables continuous DC estimation.
- `i_iqdata_fp`, in, 1: one-cycle strobe. It qualifies `i_idata` and `i_qdata`.
- `i_idata`, in, DW, signed: raw I sample from the receive interface.
- `i_qdata`, in, DW, signed: raw Q sample.
- `o_iqdata_fp`, out, 1: output strobe. It is the input strobe delayed by 2 cycles.
- `o_idata`, out, DW, signed: corrected I sample.
- `o_qdata`, out, DW, signed: corrected Q sample.
- `o_est_valid`, out, 1: one-cycle pulse when a new estimate is loaded.
- `o_dc_est_i`, out, DW, signed: current I DC estimate.
- `o_dc_est_q`, out, DW, signed: current Q DC estimate.

## Operation
- **Datapath stage 1 (on strobe):**
  - Sign-extend the sample, the estimate and the trim to DW+2 bits.
  - Compute `d = x − dc_est − trim`, separately for I and Q.
  - If bypass is set, `d = x`.
- **Datapath stage 2:**
  - Saturate `d` to [−2^(DW−1), 2^(DW−1)−1].
  - Register the result to the outputs together with the delayed strobe.
- **Output holding:** when no strobe is present, the outputs hold their last value and `o_iqdata_fp` is 0.
- **Estimation input:** the estimator always accumulates the raw input, never the corrected output (open loop). Bypass does not stop estimation.
- **Accumulators:** one per channel, signed, DW+ACC_LOG2 bits wide. They cannot overflow.
- **Estimator FSM, shared by I and Q:**
  - IDLE:
    - Accumulators and counter are held at 0.
    - If `i_est_en`=1, go to ACCUM next cycle.
  - ACCUM:
    - On each strobe, `acc += x` and `cnt += 1`.
    - When a strobe arrives with `cnt == 2^ACC_LOG2−1`, go to UPDATE.
    - If `i_est_en`=0 in any cycle, abort to IDLE. The accumulators are discarded and the estimate is unchanged.
  - UPDATE, one cycle:
    - Set `dc_est = acc >>> ACC_LOG2` (arithmetic shift, so the result rounds toward −∞).
    - Pulse `o_est_valid`.
    - If a strobe is present in this cycle, its sample starts the next window (`acc = x`, `cnt = 1`). Otherwise `acc = 0` and `cnt = 0`.
    - Next state is ACCUM if `i_est_en`=1, else IDLE (the accumulators are cleared).
- **Estimate hold:** the estimate persists indefinitely while `i_est_en`=0.

## Timing
- Latency is exactly 2 cycles from `i_iqdata_fp` to `o_iqdata_fp`, in both corrected and bypass modes.
- Back-to-back strobes (one every cycle) are supported with no stalls.
- A new `dc_est` applies to samples whose strobe arrives in the cycle after UPDATE or later. The sample strobed in the UPDATE cycle itself uses the old estimate.
- The trim inputs and bypass are sampled at stage 1 only. Changes apply per sample with no glitch.
- Reset values, all applying on the next clock edge: every output is 0, `dc_est` is 0, the FSM is in IDLE, and all pipeline registers are 0.
- Reset asserted mid-window discards the partial sums, and no `o_est_valid` is issued.
- Strobes arriving while reset is asserted are dropped.

## Structure
- Shared package `ad80305_pkg` holds:
  - `DW`,
  - the saturation limits,
  - the estimator state enum (IDLE, ACCUM, UPDATE).
- Sub-module `ad80305_dc_est` contains the FSM, the window counter, both accumulators and the estimate registers.
- The top level contains the 2-stage subtract/saturate pipeline and instantiates `ad80305_dc_est` once.

## Test plan
- **Bypass:** bypass=1, trim I=5/Q=−3, input I=100/Q=−50 strobed → 2 cycles later the output strobe is 1 and the output is I=100, Q=−50.
- **Trim only:** bypass=0, `i_est_en`=0, trim I=5/Q=−3, input I=100/Q=−50 → output I=95, Q=−47 with 2-cycle latency.
- **Saturation:**
  - I=2047 with trim −10 → 2047.
  - Q=−2048 with trim 10 → −2048.
  - I=2040 with trim −5 → 2045.
- **Estimation, `ACC_LOG2`=4:**
  - Constant input I=40/Q=−24 with `i_est_en`=1 for 16 back-to-back strobes → exactly one `o_est_valid` pulse.
  - After the pulse, `o_dc_est_i`=40 and `o_dc_est_q`=−24.
  - The following samples output 0/0.
- **Rounding, `ACC_LOG2`=4:** I alternating −1,0 over 16 strobes → `o_dc_est_i`=−1 (sum −8 floors to −1).
- **Abort and reset:**
  - Drop `i_est_en` after strobe 10 → no pulse and the estimate is unchanged.
  - Assert reset during ACCUM → all outputs read 0 on the next edge and the window restarts from 0.
